// File: rtl/rosetta_fetch_unit_pkg.sv
// Shared definitions for the rosetta fetch/sequencing stage: sizes, state encoding
// and instruction field positions used by the core controller.
package rosetta_fetch_unit_pkg;

    localparam int INST_W   = 28;
    localparam int ADDR_W   = 10;
    localparam int NOP_LONG = 3;
    localparam int CNT_W    = 2;

    localparam int NOPS_BIT   = 1;
    localparam int LAST_BIT   = 2;
    localparam int FP_IN1_LSB = 3;
    localparam int FP_IN1_MSB = 4;
    localparam int FP_IN0_LSB = 5;
    localparam int FP_IN0_MSB = 6;
    localparam int FP_OUT_LSB = 7;
    localparam int FP_OUT_MSB = 8;
    localparam int INV_BIT    = 11;
    localparam int ACC_BIT    = 12;
    localparam int ACT_BIT    = 13;
    localparam int OP_BIT     = 15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_BUBBLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Counter preload for the long bubble; the zero cycle is the last bubble cycle.
    localparam logic [CNT_W-1:0] BUBBLE_LONG_LOAD = CNT_W'(NOP_LONG - 1);

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] cur_pc);
        return cur_pc + 1'b1;
    endfunction

endpackage

// File: rtl/rosetta_fetch_unit_if.sv
// Bundle of the fetch unit's program-control, instruction-memory and controller signals.
// Handshake: a read issued with im_ren=1 at address im_addr returns im_rdata the following
// cycle; done_wen is a one-cycle completion strobe honoured only while nop=0.
interface rosetta_fetch_unit_if;
    import rosetta_fetch_unit_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] start_pc;
    logic              im_ren;
    logic [ADDR_W-1:0] im_addr;
    logic [INST_W-1:0] im_rdata;
    logic              done_wen;
    logic              stall_fetch;
    logic              nops_encod;
    logic              last_inst;
    logic [INST_W-1:0] inst;
    logic              nop;
    logic              stall_done;
    logic              all_done;
    logic [ADDR_W-1:0] pc;

    modport master (
        input  start, start_pc, im_rdata, done_wen, stall_fetch, nops_encod, last_inst,
        output im_ren, im_addr, inst, nop, stall_done, all_done, pc
    );

    modport slave (
        output start, start_pc, im_rdata, done_wen, stall_fetch, nops_encod, last_inst,
        input  im_ren, im_addr, inst, nop, stall_done, all_done, pc
    );

endinterface

// File: rtl/rosetta_bubble_cnt.sv
// Down-counter timing the NOP bubble after each retired instruction.
// Loads on retire, decrements while counting, saturates at zero.
module rosetta_bubble_cnt
    import rosetta_fetch_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rosetta_fetch_unit.sv
// Instruction fetch and sequencing stage: fetches, holds the instruction during
// execution, then runs the NOP bubble before advancing or finishing the program.
module rosetta_fetch_unit
    import rosetta_fetch_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    rosetta_fetch_unit_if.master  bus,
    output state_t                state_dbg_o
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic              im_ren_q, im_ren_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              last_q, last_d;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_zero;

    rosetta_bubble_cnt u_bubble_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (state_q == ST_BUBBLE),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        im_addr_d    = im_addr_q;
        im_ren_d     = 1'b0;
        inst_d       = inst_q;
        last_d       = last_q;
        cnt_load     = 1'b0;
        cnt_load_val = bus.nops_encod ? BUBBLE_LONG_LOAD : '0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    pc_d      = bus.start_pc;
                    im_addr_d = bus.start_pc;
                    im_ren_d  = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            // While im_ren_q is high the read is being issued; data lands one cycle later.
            ST_FETCH: begin
                if (!im_ren_q) begin
                    inst_d  = bus.im_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (bus.done_wen) begin
                    last_d   = bus.last_inst;
                    cnt_load = 1'b1;
                    state_d  = ST_BUBBLE;
                end
            end
            ST_BUBBLE: begin
                if (cnt_zero && !bus.stall_fetch) begin
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        pc_d      = next_pc(pc_q);
                        im_addr_d = next_pc(pc_q);
                        im_ren_d  = 1'b1;
                        state_d   = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            im_addr_q <= '0;
            im_ren_q  <= 1'b0;
            inst_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            im_addr_q <= im_addr_d;
            im_ren_q  <= im_ren_d;
            inst_q    <= inst_d;
            last_q    <= last_d;
        end
    end

    assign bus.im_ren     = im_ren_q;
    assign bus.im_addr    = im_addr_q;
    assign bus.inst       = inst_q;
    assign bus.pc         = pc_q;
    assign bus.nop        = (state_q != ST_EXEC);
    assign bus.stall_done = (state_q == ST_BUBBLE) && cnt_zero;
    assign bus.all_done   = (state_q == ST_DONE);
    assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_rosetta_fetch_unit.sv
// Bench for rosetta_fetch_unit: a controller driver runs randomized programs out of a
// bench-owned memory; a monitor checks each presented instruction against the expected queue.
module tb_rosetta_fetch_unit;
  import rosetta_fetch_unit_pkg::*;

  localparam int W     = ADDR_W + INST_W;
  localparam int DEPTH = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  state_t st_dbg;

  rosetta_fetch_unit_if bus();

  logic [INST_W-1:0] mem [0:DEPTH-1];
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int pc_m;

  always #5 clk = ~clk;

  rosetta_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .state_dbg_o (st_dbg)
  );

  // Synchronous instruction memory: data one cycle after the read enable.
  always @(posedge clk) begin
    if (bus.im_ren) bus.im_rdata <= mem[bus.im_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every time an instruction becomes executable, it must match the next expected one.
  logic prev_nop = 1'b1;
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      prev_nop = 1'b1;
    end else begin
      if (prev_nop && !bus.nop) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL exec_unexpected actual_pc=%0h expected=none", bus.pc);
        end else begin
          e = exp_q.pop_front();
          check("exec_pc", 32'(bus.pc), 32'(e[W-1:INST_W]));
          check("exec_inst", 32'(bus.inst), 32'(e[INST_W-1:0]));
        end
      end
      prev_nop = bus.nop;
    end
  end

  task automatic load_prog(input int spc, input int n);
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = INST_W'($urandom);
      mem[i][LAST_BIT] = 1'b0;
    end
    mem[(spc + n - 1) % DEPTH][LAST_BIT] = 1'b1;
  endtask

  task automatic push_exp();
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(pc_m);
    exp_q.push_back({a, mem[pc_m]});
  endtask

  // Called at a negedge in IDLE or DONE; returns at the first EXEC negedge.
  task automatic start_prog(input int spc);
    bus.start = 1'b1;
    bus.start_pc = ADDR_W'(spc);
    pc_m = spc;
    push_exp();
    @(negedge clk);
    bus.start = 1'b0;
    bus.start_pc = ADDR_W'($urandom_range(0, DEPTH - 1));
    check("t1_im_addr", 32'(bus.im_addr), 32'(spc));
    check("t1_im_ren", 32'(bus.im_ren), 1);
    check("t1_all_done", 32'(bus.all_done), 0);
    check("t1_nop", 32'(bus.nop), 1);
    @(negedge clk);
    check("t2_im_ren", 32'(bus.im_ren), 0);
    check("t2_nop", 32'(bus.nop), 1);
    @(negedge clk);
    check("t3_nop", 32'(bus.nop), 0);
  endtask

  // Executes the current instruction as the controller would; hold<0 picks a random stall.
  task automatic exec_inst(output bit last, input int hold);
    logic [INST_W-1:0] cur;
    int bl, h, k, held, n;
    bit ok;
    cur = mem[pc_m];
    last = cur[LAST_BIT];
    repeat ($urandom_range(0, 3)) begin
      bus.start = 1'($urandom_range(0, 1));
      bus.start_pc = ADDR_W'($urandom_range(0, DEPTH - 1));
      @(negedge clk);
      bus.start = 1'b0;
      check("exec_hold_inst", 32'(bus.inst), 32'(cur));
      check("exec_hold_pc", 32'(bus.pc), 32'(pc_m));
      check("exec_nop", 32'(bus.nop), 0);
    end
    h = (hold < 0) ? $urandom_range(0, 2) : hold;
    bl = cur[NOPS_BIT] ? NOP_LONG : 1;
    bus.done_wen = 1'b1;
    bus.nops_encod = cur[NOPS_BIT];
    bus.last_inst = cur[LAST_BIT];
    bus.stall_fetch = (h > 0);
    @(negedge clk);
    bus.done_wen = 1'b0;
    bus.nops_encod = 1'($urandom);
    bus.last_inst = 1'($urandom);
    k = 0;
    held = 0;
    ok = 1'b0;
    while (k < 20 && !ok) begin
      k++;
      check("bubble_nop", 32'(bus.nop), 1);
      check("bubble_stall_done", 32'(bus.stall_done), (k >= bl) ? 1 : 0);
      if (k >= bl) begin
        check("bubble_pc", 32'(bus.pc), 32'(pc_m));
        if (held == h) begin
          bus.stall_fetch = 1'b0;
          ok = 1'b1;
        end else begin
          held++;
        end
      end
      @(negedge clk);
    end
    if (last) begin
      check("done_all_done", 32'(bus.all_done), 1);
      check("done_nop", 32'(bus.nop), 1);
      repeat (3) begin
        @(negedge clk);
        check("done_im_ren", 32'(bus.im_ren), 0);
        check("done_sticky", 32'(bus.all_done), 1);
      end
    end else begin
      pc_m = (pc_m + 1) % DEPTH;
      push_exp();
      check("next_im_addr", 32'(bus.im_addr), 32'(pc_m));
      check("next_im_ren", 32'(bus.im_ren), 1);
      check("next_stall_done", 32'(bus.stall_done), 0);
      n = 0;
      while (bus.nop && n < 6) begin
        @(negedge clk);
        n++;
      end
      check("next_latency", 32'(n), 2);
    end
  endtask

  task automatic run_prog(input int spc, input int n);
    bit last;
    int guard;
    load_prog(spc, n);
    start_prog(spc);
    last = 1'b0;
    guard = 0;
    while (!last && guard < n + 2) begin
      exec_inst(last, -1);
      guard++;
    end
    check("prog_len", 32'(guard), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit last;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.start_pc = '0;
    bus.done_wen = 1'b0;
    bus.stall_fetch = 1'b0;
    bus.nops_encod = 1'b0;
    bus.last_inst = 1'b0;
    bus.im_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_inst", 32'(bus.inst), 0);
    check("rst_pc", 32'(bus.pc), 0);
    check("rst_im_addr", 32'(bus.im_addr), 0);
    check("rst_im_ren", 32'(bus.im_ren), 0);
    check("rst_nop", 32'(bus.nop), 1);
    check("rst_stall_done", 32'(bus.stall_done), 0);
    check("rst_all_done", 32'(bus.all_done), 0);
    rst = 1'b0;
    @(negedge clk);

    // First instruction short bubble, second long bubble with a two-cycle stall, then done.
    load_prog(5, 2);
    mem[5] = 28'h0000001;
    mem[6][NOPS_BIT] = 1'b1;
    start_prog(5);
    exec_inst(last, 0);
    check("dir_first_not_last", 32'(last), 0);
    exec_inst(last, 2);
    check("dir_second_last", 32'(last), 1);

    // Restart from DONE.
    run_prog(100, 3);

    // Address wrap at the top of memory.
    load_prog(DEPTH - 1, 2);
    start_prog(DEPTH - 1);
    exec_inst(last, -1);
    check("wrap_pc", 32'(pc_m), 0);
    exec_inst(last, -1);

    repeat (6) run_prog($urandom_range(0, DEPTH - 1), $urandom_range(1, 5));

    // Reset in the middle of a long bubble, then a stray done_wen in IDLE.
    load_prog(40, 2);
    mem[40][NOPS_BIT] = 1'b1;
    start_prog(40);
    bus.done_wen = 1'b1;
    bus.nops_encod = 1'b1;
    bus.last_inst = 1'b0;
    @(negedge clk);
    bus.done_wen = 1'b0;
    check("rb_stall_done_k1", 32'(bus.stall_done), 0);
    @(negedge clk);
    check("rb_stall_done_k2", 32'(bus.stall_done), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rb_nop", 32'(bus.nop), 1);
    check("rb_stall_done", 32'(bus.stall_done), 0);
    check("rb_inst", 32'(bus.inst), 0);
    check("rb_pc", 32'(bus.pc), 0);
    check("rb_im_ren", 32'(bus.im_ren), 0);
    bus.done_wen = 1'b1;
    bus.nops_encod = 1'($urandom);
    bus.last_inst = 1'($urandom);
    @(negedge clk);
    bus.done_wen = 1'b0;
    repeat (3) begin
      check("idle_nop", 32'(bus.nop), 1);
      check("idle_stall_done", 32'(bus.stall_done), 0);
      check("idle_im_ren", 32'(bus.im_ren), 0);
      check("idle_all_done", 32'(bus.all_done), 0);
      @(negedge clk);
    end

    run_prog($urandom_range(0, DEPTH - 1), 2);

    check("exp_q_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
